// File: rtl/seq_scan_ctrl.sv
// Frame-level serial pattern-scan controller: accepts words on valid/ready, shifts them MSB-first
// into a programmable Moore detector and reports per-frame match counts. Optional macro: PAT_OVERLAP_EN.
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1010,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              busy,
  output logic              bit_out,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              done
);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, NEXT, DONE} state_t;
  state_t state, state_nxt;

  logic [PAT_W-1:0]  pat, win, win_nxt;
  logic [FILL_W-1:0] fill, fill_nxt;
  logic [DATA_W-1:0] word;
  logic              last;
  logic [IDX_W-1:0]  bit_idx;
  logic              accept, hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (bit_idx == '0) state_nxt = last ? DONE : NEXT;
      NEXT:    if (in_valid) state_nxt = SHIFT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) || (state == NEXT);
    busy     = (state != IDLE);
    done     = (state == DONE);
    bit_out  = (state == SHIFT) ? word[bit_idx] : 1'b0;
  end

  // Detector update for the bit being shifted this cycle; window MSB is the oldest bit.
  assign accept   = in_valid && in_ready;
  assign win_nxt  = {win[PAT_W-2:0], bit_out};
  assign fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;
  assign hit      = (state == SHIFT) && (win_nxt == pat) && (fill_nxt == FILL_W'(PAT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat       <= PAT_RST;
      win       <= '0;
      fill      <= '0;
      word      <= '0;
      last      <= 1'b0;
      bit_idx   <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else begin
      match <= hit;
      if (cfg_we && state == IDLE) pat <= cfg_pat;
      if (accept) begin
        word    <= in_data;
        last    <= in_last;
        bit_idx <= IDX_W'(DATA_W - 1);
        if (state == IDLE) begin
          win       <= '0;
          fill      <= '0;
          match_cnt <= '0;
        end
      end
      if (state == SHIFT) begin
        bit_idx <= bit_idx - 1'b1;
        win     <= win_nxt;
`ifdef PAT_OVERLAP_EN
        fill    <= fill_nxt;
`else
        fill    <= hit ? '0 : fill_nxt;
`endif
        if (hit && match_cnt != {CNT_W{1'b1}}) match_cnt <= match_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: frames are scored by a string-search model and
// checked at each done pulse on a default instance and a CNT_W=4 instance.
module tb_seq_scan_ctrl;
  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
`ifdef PAT_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_we = 1'b0;
  logic [PAT_W-1:0]  cfg_pat = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready, busy, bit_out, match, done;
  logic [7:0]        match_cnt;
  logic              in_ready_s, busy_s, bit_out_s, match_s, done_s;
  logic [3:0]        match_cnt_s;

  seq_scan_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .busy(busy), .bit_out(bit_out), .match(match),
    .match_cnt(match_cnt), .done(done)
  );

  seq_scan_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pat(cfg_pat),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready_s), .busy(busy_s), .bit_out(bit_out_s), .match(match_s),
    .match_cnt(match_cnt_s), .done(done_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  logic [PAT_W-1:0] pat_m = 4'b1010;
  logic [7:0] wq[$];
  int last_exp = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Count pattern occurrences in the frame's bit string; disjoint mode resumes after a hit.
  function automatic int count_hits(input bit bits[$], input logic [PAT_W-1:0] p);
    int c = 0;
    int min_end = PAT_W - 1;
    for (int i = PAT_W - 1; i < bits.size(); i++) begin
      bit ok = 1'b1;
      if (i < min_end) continue;
      for (int k = 0; k < PAT_W; k++)
        if (bits[i-PAT_W+1+k] != p[PAT_W-1-k]) ok = 1'b0;
      if (ok) begin
        c++;
        min_end = OVL ? i + 1 : i + PAT_W;
      end
    end
    return c;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: pops one expectation per done pulse.
  int pulses = 0, cyc = 0, acc_cyc = -1, raw = 0;
  bit prev_done = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pulses = 0;
      prev_done = 1'b0;
    end else begin
      if (match) pulses++;
      if (done) begin
        check("done_single", int'(prev_done), 0);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          raw = exp_q.pop_front();
          last_exp = sat(raw, 255);
          check("match_cnt", int'(match_cnt), sat(raw, 255));
          check("match_cnt_sat4", int'(match_cnt_s), sat(raw, 15));
          check("match_pulses", pulses, raw);
          check("done_latency", cyc - acc_cyc, DATA_W + 1);
          check("ready_in_done", int'(in_ready), 0);
          check("sat_inst_done", int'(done_s), 1);
        end
        pulses = 0;
      end
      prev_done = done;
      if (in_valid && in_ready && in_last) acc_cyc = cyc;
    end
  end

  task automatic put_word(input logic [7:0] d, input bit l, input bit we, input logic [PAT_W-1:0] p);
    bit got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l; cfg_we = we; cfg_pat = p;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) check("ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  // gap < 0 picks a random idle gap after each word; shift_cfg pokes cfg_we while shifting.
  task automatic send_frame(input int gap, input bit we, input logic [PAT_W-1:0] p, input bit shift_cfg);
    bit bits[$];
    int g;
    if (we) pat_m = p;
    for (int i = 0; i < wq.size(); i++)
      for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(wq[i][b]);
    exp_q.push_back(count_hits(bits, pat_m));
    for (int i = 0; i < wq.size(); i++) begin
      put_word(wq[i], i == wq.size() - 1, (i == 0) ? we : 1'b0, p);
      if (shift_cfg && i == 0) begin
        cfg_we = 1'b1; cfg_pat = ~pat_m;
        repeat (2) @(posedge clk);
        #1 cfg_we = 1'b0;
      end
      g = (gap < 0) ? int'($urandom_range(0, 12)) : gap;
      repeat (g) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #3;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_match", int'(match), 0);
    check("rst_bit_out", int'(bit_out), 0);
    #14 rst = 1'b1;
    @(posedge clk); #1;

    wq = {8'hAA};                 send_frame(-1, 1'b0, 4'b0000, 1'b0);
    wq = {8'h05, 8'h00};          send_frame(11, 1'b0, 4'b0000, 1'b0);
    wq = {8'hAA};                 send_frame(-1, 1'b0, 4'b0000, 1'b1);
    wq = {8'hFF};                 send_frame(-1, 1'b1, 4'b1111, 1'b0);
    wq = {8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    send_frame(-1, 1'b1, 4'b1010, 1'b0);
    for (int f = 0; f < 3; f++) begin
      wq = {8'(($urandom % 2) ? 8'hAA : $urandom), 8'h5A};
      send_frame(0, 1'b0, 4'b0000, 1'b0);
    end

    // Abort a frame with reset while shifting; pattern must return to 1010.
    wq = {8'h36};                 send_frame(-1, 1'b1, 4'b0110, 1'b0);
    put_word(8'hAA, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_match_cnt", int'(match_cnt), 0);
    check("abort_done", int'(done), 0);
    @(posedge clk); #1 rst = 1'b1;
    pat_m = 4'b1010;
    @(posedge clk); #1;
    wq = {8'hAA};                 send_frame(-1, 1'b0, 4'b0000, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int nw = $urandom_range(1, 4);
      wq.delete();
      for (int i = 0; i < nw; i++) wq.push_back(($urandom % 3 == 0) ? 8'hAA : 8'($urandom));
      send_frame(($urandom % 3 == 0) ? 0 : -1, ($urandom % 2) == 1, 4'($urandom),
                 ($urandom % 4) == 0);
    end

    for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge clk);
    check("drain", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1 check("cnt_hold", int'(match_cnt), last_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
